vga_timing_core: RTL and testbench

- Parametrised VGA timing and pixel-fetch core; the next generation of the fixed 640x480 `vga_driver`.
- Sits between the PLL pixel clock and the display/game renderer.
- Generates sync/blanking from configurable timing.
- Issues pixel coordinate requests PIX_LAT cycles early, so the renderer can use pipelined or RAM-based lookups.
- Adds integer down-scaling and a built-in colour-bar test pattern.

---
 rtl/vga_timing_core.sv | 134 +++++++++++++
 tb/tb_vga_timing_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// VGA timing generator with early pixel-coordinate requests, integer down-scaling
// and a built-in colour-bar test pattern.
module vga_timing_core #(
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned RGB_W      = 3,
    parameter int unsigned PIX_LAT    = 1,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 10
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic             test_pattern,
    input  logic [RGB_W-1:0] pixel_data,
    output logic             pixel_req,
    output logic [XW-1:0]    pixel_xpos,
    output logic [YW-1:0]    pixel_ypos,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             frame_start,
    output logic             line_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HA0     = H_SYNC + H_BP;
    localparam int unsigned HA1     = HA0 + H_ACTIVE;
    localparam int unsigned VA0     = V_SYNC + V_BP;
    localparam int unsigned VA1     = VA0 + V_ACTIVE;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned CW      = RGB_W / 3;

    if (PIX_LAT < 1 || PIX_LAT > H_BP) begin : g_bad_pix_lat
        $error("vga_timing_core: PIX_LAT must be in 1..H_BP");
    end
    if (RGB_W % 3 != 0) begin : g_bad_rgb_w
        $error("vga_timing_core: RGB_W must be a multiple of 3");
    end

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [31:0]      h_pos, v_pos, h_ahead, x_rel, y_rel, x_bar;
    logic             h_act, v_act, ahead_act;
    logic [2:0]       bar_idx, bar_colour;
    logic [RGB_W-1:0] bar_rgb, rgb_next;
    logic             hs_next, vs_next;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == VW'(V_TOTAL - 1)) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        h_pos     = 32'(h_cnt);
        v_pos     = 32'(v_cnt);
        h_ahead   = h_pos + PIX_LAT;
        h_act     = (h_pos >= HA0) && (h_pos < HA1);
        v_act     = (v_pos >= VA0) && (v_pos < VA1);
        ahead_act = (h_ahead >= HA0) && (h_ahead < HA1);
        x_rel     = h_ahead - HA0;
        y_rel     = v_pos - VA0;

        pixel_req  = ahead_act && v_act;
        pixel_xpos = '0;
        pixel_ypos = '0;
        if (pixel_req) begin
            pixel_xpos = XW'(x_rel >> SCALE_LOG2);
            pixel_ypos = YW'(y_rel >> SCALE_LOG2);
        end
    end

    // Bar index = number of bar boundaries already passed: x*8 >= k*H_ACTIVE.
    always_comb begin
        x_bar   = h_pos - HA0;
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if ((x_bar << 3) >= k * H_ACTIVE) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
        bar_colour = 3'd7 - bar_idx;
        bar_rgb    = {{CW{bar_colour[2]}}, {CW{bar_colour[1]}}, {CW{bar_colour[0]}}};
    end

    always_comb begin
        hs_next  = (h_pos < H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_next  = (v_pos < V_SYNC) ? SYNC_POL : ~SYNC_POL;
        rgb_next = '0;
        if (h_act && v_act) begin
            rgb_next = test_pattern ? bar_rgb : pixel_data;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            vga_hs      <= hs_next;
            vga_vs      <= vs_next;
            vga_de      <= h_act && v_act;
            vga_rgb     <= rgb_next;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_start  <= (h_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// Scoreboard bench for vga_timing_core on a reduced timing set with a
// latency-3 renderer model, 2x scaling, colour bars and a mid-frame reset.
module tb_vga_timing_core;

    localparam int unsigned HS   = 4;
    localparam int unsigned HBP  = 6;
    localparam int unsigned HACT = 16;
    localparam int unsigned HFP  = 3;
    localparam int unsigned VS   = 2;
    localparam int unsigned VBP  = 3;
    localparam int unsigned VACT = 6;
    localparam int unsigned VFP  = 2;
    localparam logic        POL  = 1'b1;
    localparam int unsigned LAT  = 3;
    localparam int unsigned SC   = 1;
    localparam int unsigned HT   = HS + HBP + HACT + HFP;
    localparam int unsigned VT   = VS + VBP + VACT + VFP;
    localparam int unsigned HA0  = HS + HBP;
    localparam int unsigned VA0  = VS + VBP;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] rgb;
        logic       fs;
        logic       ls;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tp = 1'b0;
    logic [5:0] pdata = '0;
    logic       pixel_req;
    logic [5:0] pixel_xpos, pixel_ypos;
    logic       vga_hs, vga_vs, vga_de, frame_start, line_start;
    logic [5:0] vga_rgb;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned m_h, m_v, since_rel;
    bit          de_seen;
    logic [5:0]  pipe[LAT];
    exp_t        reset_vals;

    always #5 clk = ~clk;

    vga_timing_core #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HACT), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VACT), .V_FP(VFP),
        .SYNC_POL(POL), .RGB_W(6), .PIX_LAT(LAT), .SCALE_LOG2(SC),
        .XW(6), .YW(6)
    ) dut (
        .vga_clk(clk), .sys_rst_n(rst_n), .test_pattern(tp), .pixel_data(pdata),
        .pixel_req(pixel_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
        .frame_start(frame_start), .line_start(line_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t h=%0d v=%0d)", tag, got, exp, $time, m_h, m_v);
    endtask

    function automatic logic [5:0] render(input logic [31:0] x, input logic [31:0] y);
        return {x[2:0], y[1:0], 1'b1};
    endfunction

    function automatic exp_t model_out(input int unsigned h, input int unsigned v, input logic t);
        exp_t        e;
        int unsigned b;
        logic [2:0]  c;
        e.hs  = (h < HS) ? POL : !POL;
        e.vs  = (v < VS) ? POL : !POL;
        e.de  = (h >= HA0 && h < HA0 + HACT) && (v >= VA0 && v < VA0 + VACT);
        e.rgb = '0;
        if (e.de) begin
            if (t) begin
                b = ((h - HA0) * 8) / HACT;
                c = 3'(7 - b);
                e.rgb = {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
            end else begin
                e.rgb = render((h - HA0) >> SC, (v - VA0) >> SC);
            end
        end
        e.fs = (h == 0) && (v == 0);
        e.ls = (h == 0);
        return e;
    endfunction

    task automatic check_regs(input exp_t e);
        check_eq("vga_hs", 32'(vga_hs), 32'(e.hs));
        check_eq("vga_vs", 32'(vga_vs), 32'(e.vs));
        check_eq("vga_de", 32'(vga_de), 32'(e.de));
        check_eq("vga_rgb", 32'(vga_rgb), 32'(e.rgb));
        check_eq("frame_start", 32'(frame_start), 32'(e.fs));
        check_eq("line_start", 32'(line_start), 32'(e.ls));
    endtask

    task automatic step();
        int unsigned ahead;
        logic        req, v_act;
        logic [5:0]  captured;
        if (sb.size() != 0) check_regs(sb.pop_front());
        ahead = m_h + LAT;
        v_act = (m_v >= VA0) && (m_v < VA0 + VACT);
        req   = (ahead >= HA0) && (ahead < HA0 + HACT) && v_act;
        check_eq("pixel_req", 32'(pixel_req), 32'(req));
        check_eq("pixel_xpos", 32'(pixel_xpos), req ? (ahead - HA0) >> SC : 0);
        check_eq("pixel_ypos", 32'(pixel_ypos), req ? (m_v - VA0) >> SC : 0);
        if (!de_seen && vga_de) begin
            de_seen = 1'b1;
            check_eq("de_rise_delay", since_rel, VA0 * HT + HA0 + 1);
        end
        captured = pixel_req ? render(32'(pixel_xpos), 32'(pixel_ypos)) : '0;
        sb.push_back(model_out(m_h, m_v, tp));
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = captured;
        pdata   = pipe[LAT-1];
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        since_rel++;
        @(negedge clk);
    endtask

    // Entered at a negedge; asserting reset between edges shows it acts asynchronously.
    task automatic apply_reset(input int unsigned hold);
        rst_n = 1'b0;
        #1;
        check_regs(reset_vals);
        check_eq("rst_pixel_req", 32'(pixel_req), 0);
        check_eq("rst_pixel_xpos", 32'(pixel_xpos), 0);
        check_eq("rst_pixel_ypos", 32'(pixel_ypos), 0);
        sb.delete();
        m_h = 0;
        m_v = 0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        pdata = '0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_regs(reset_vals);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(reset_vals);
        since_rel = 0;
        de_seen   = 1'b0;
    endtask

    initial begin
        int unsigned n;
        reset_vals = '{hs: !POL, vs: !POL, de: 1'b0, rgb: 6'd0, fs: 1'b0, ls: 1'b0};
        m_h = 0;
        m_v = 0;
        @(negedge clk);
        apply_reset(5);

        repeat (VT * HT + 100) step();

        tp = 1'b1;
        repeat (VT * HT) step();

        for (int i = 0; i < 80; i++) begin
            if (i % 5 == 0) tp = ~tp;
            step();
        end
        tp = 1'b0;

        n = 0;
        while (!(m_v == VA0 + 2 && m_h == HA0 + 5) && n < VT * HT) begin
            step();
            n++;
        end
        check_eq("reach_reset_point", n < VT * HT, 1);
        apply_reset(5);

        repeat (VT * HT + 200) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
